clk_div_ctrl: RTL

- Runtime-programmable controller for the odd/even clock-divider datapath.
- Accepts a divide ratio through a valid/ready config port and runs the period counter.
- Generates the posedge-domain divided phase plus an odd flag; downstream negedge/OR logic uses the flag to form 50% duty on odd ratios.
- Ratio changes and stops are applied only on period boundaries, so the divided clock never glitches.

---
 rtl/clk_div_pkg.sv | 26 ++
 rtl/clk_div_cnt.sv | 78 +++++++
 rtl/clk_div_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the programmable clock-divider controller.
//   CLK_DIV_W : default ratio/counter width. It also sets the width of the
//               pending-request struct, so a DIV_W override must match it.
//   DIV_MIN   : smallest legal divide ratio.
//   state_t   : controller FSM states.
//   pend_t    : a config request parked until the next period boundary.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int unsigned CLK_DIV_W = 4;
  localparam int unsigned DIV_MIN   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  typedef struct packed {
    logic                 en;
    logic [CLK_DIV_W-1:0] div;
  } pend_t;

endpackage

// File: rtl/clk_div_cnt.sv
// -----------------------------------------------------------------------------
// clk_div_cnt
// Period counter and phase generator for the clock divider.
// Every output flop is loaded from the *next* counter/ratio value, so div_p,
// tick and the ratio all change on the same edge as the counter itself.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_run      : divider is running after this edge
//   i_load     : restart the period at i_div (cnt=0) on this edge
//   i_div      : ratio to load
//   o_last     : current cycle is the last of the period (cnt == ratio-1)
//   o_ratio    : ratio in effect
//   o_div_p    : divided phase, high for ratio>>1 cycles of each period
//   o_tick     : high on the last cycle of each period
// -----------------------------------------------------------------------------
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = CLK_DIV_W,
  parameter int DEF_DIV = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_last,
  output logic [DIV_W-1:0] o_ratio,
  output logic             o_div_p,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_ratio;
  logic             r_div_p;
  logic             r_tick;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_ratio_nxt;
  logic             w_last;

  assign w_last = (r_cnt == r_ratio - DIV_W'(1));

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_ratio_nxt = r_ratio;
    if (!i_run) begin
      // Stopping keeps the last ratio visible; only the count is cleared.
      w_cnt_nxt = '0;
    end else if (i_load) begin
      w_cnt_nxt   = '0;
      w_ratio_nxt = i_div;
    end else if (w_last) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ratio <= DIV_W'(DEF_DIV);
      r_div_p <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      r_div_p <= i_run && (w_cnt_nxt < (w_ratio_nxt >> 1));
      r_tick  <= i_run && (w_cnt_nxt == w_ratio_nxt - DIV_W'(1));
    end
  end

  assign o_last  = w_last;
  assign o_ratio = r_ratio;
  assign o_div_p = r_div_p;
  assign o_tick  = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Runtime-programmable controller for the odd/even clock divider. Accepts a
// ratio over a valid/ready port and applies changes and stops only on period
// boundaries, so the divided phase never glitches. div_odd tells downstream
// negedge/OR logic to stretch the phase to 50% duty on odd ratios.
// Optional feature macro: CLK_DIV_PERIOD_CNT_EN builds the 16-bit completed
// period counter; without it period_cnt is tied to zero.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cfg_valid   : config request;     cfg_ready : config can be accepted
//   cfg_en      : 1 = run at cfg_div, 0 = stop;  cfg_div : requested ratio
//   cfg_err     : one-cycle pulse after an accepted ratio below 2
//   div_p       : divided phase;      div_odd   : current ratio is odd
//   div_tick    : last cycle of each period;     running : not idle
//   cur_div     : ratio in effect;    period_cnt: completed periods
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = CLK_DIV_W,
  parameter int DEF_DIV = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             div_p,
  output logic             div_odd,
  output logic             div_tick,
  output logic             running,
  output logic [DIV_W-1:0] cur_div,
  output logic [15:0]      period_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  pend_t            r_pend;
  pend_t            w_pend_nxt;
  logic             r_err;
  logic             w_xfer;
  logic             w_bad;
  logic             w_last;
  logic             w_run;
  logic             w_load;
  logic [DIV_W-1:0] w_load_div;

  assign cfg_ready = (r_state != PEND);
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_bad     = cfg_en && (cfg_div < DIV_W'(DIV_MIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_err   <= w_xfer && w_bad;
    end
  end

  // An invalid request is consumed but otherwise ignored. A legal request
  // arriving on the last cycle of a period takes effect immediately; one
  // arriving mid-period is parked until the period ends.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_run       = (r_state != IDLE);
    w_load      = 1'b0;
    w_load_div  = cfg_div;
    case (r_state)
      IDLE: begin
        if (w_xfer && cfg_en && !w_bad) begin
          w_state_nxt = RUN;
          w_run       = 1'b1;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (w_xfer && !w_bad) begin
          if (w_last) begin
            if (cfg_en) begin
              w_load = 1'b1;
            end else begin
              w_run       = 1'b0;
              w_state_nxt = IDLE;
            end
          end else begin
            w_pend_nxt.en  = cfg_en;
            w_pend_nxt.div = cfg_div;
            w_state_nxt    = PEND;
          end
        end
      end
      PEND: begin
        if (w_last) begin
          if (r_pend.en) begin
            w_load      = 1'b1;
            w_load_div  = r_pend.div;
            w_state_nxt = RUN;
          end else begin
            w_run       = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_run       = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  clk_div_cnt #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_run   (w_run),
    .i_load  (w_load),
    .i_div   (w_load_div),
    .o_last  (w_last),
    .o_ratio (cur_div),
    .o_div_p (div_p),
    .o_tick  (div_tick)
  );

  assign cfg_err = r_err;
  assign running = (r_state != IDLE);
  assign div_odd = cur_div[0];

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] r_period_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_cnt <= '0;
    end else if ((r_state == IDLE) && (w_state_nxt == RUN)) begin
      r_period_cnt <= '0;
    end else if (div_tick) begin
      r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`else
  assign period_cnt = 16'd0;
`endif

endmodule
